// File: rtl/stream_pkg.sv
// Shared constants for the stream multiplexer family.
package stream_pkg;

   // Select mode encodings
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Default geometry
   localparam int unsigned NUM_CH_DEF = 4;
   localparam int unsigned DATA_W_DEF = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Rotated priority encoder: first requester at or after ptr_i (mod NUM_CH) wins.
module rr_arbiter #(
   parameter int unsigned NUM_CH = 4,
   localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [SEL_W-1:0]  ptr_i,
   input  logic              en_i,
   output logic [SEL_W-1:0]  gnt_idx_o,
   output logic              gnt_valid_o
);

   logic             found;
   logic [SEL_W-1:0] idx;

   // Scan from the pointer, wrapping around, and latch the first request found
   always_comb begin
      found     = 1'b0;
      idx       = '0;
      gnt_idx_o = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         idx = SEL_W'((int'(ptr_i) + i) % int'(NUM_CH));
         if (!found && req_i[idx]) begin
            found     = 1'b1;
            gnt_idx_o = idx;
         end
      end
      gnt_valid_o = en_i & found;
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with registered output, fixed or round-robin select.
// Note: in_ready_o depends combinationally on out_ready_i; out_data_o does not.
module stream_mux_rr
   import stream_pkg::*;
#(
   parameter int unsigned NUM_CH = NUM_CH_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mode_i,
   input  logic [SEL_W-1:0]         sel_i,
   input  logic [NUM_CH*DATA_W-1:0] in_data_i,
   input  logic [NUM_CH-1:0]        in_valid_i,
   output logic [NUM_CH-1:0]        in_ready_o,
   output logic [DATA_W-1:0]        out_data_o,
   output logic                     out_valid_o,
   output logic [SEL_W-1:0]         out_ch_o,
   input  logic                     out_ready_i
);

   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic [SEL_W-1:0]  out_ch_q, out_ch_d;
   logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

   logic              load_en;
   logic [NUM_CH-1:0] fixed_req;
   logic [NUM_CH-1:0] arb_req;
   logic [SEL_W-1:0]  gnt_idx;
   logic              gnt_valid;
   logic [DATA_W-1:0] gnt_data;

   assign load_en = ~out_valid_q | out_ready_i;

   // Fixed mode reuses the arbiter through a one-hot mask; out-of-range sel yields no request
   always_comb begin
      fixed_req = '0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
         fixed_req[k] = in_valid_i[k] & (int'(sel_i) == k);
      end
   end

   assign arb_req = (mode_i == MODE_RR) ? in_valid_i : fixed_req;

   // Gating with rst_n keeps in_ready low while reset is held
   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .req_i       (arb_req),
      .ptr_i       (rr_ptr_q),
      .en_i        (load_en & rst_n),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_valid)
   );

   assign gnt_data = in_data_i[int'(gnt_idx)*DATA_W +: DATA_W];

   // Per-channel ready: one-hot on the granted channel, zero otherwise
   always_comb begin
      in_ready_o = '0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
         in_ready_o[k] = gnt_valid & (gnt_idx == SEL_W'(k));
      end
   end

   // Next state of output stage and round-robin pointer
   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_ch_d    = out_ch_q;
      rr_ptr_d    = rr_ptr_q;
      if (load_en) begin
         out_valid_d = gnt_valid;
         if (gnt_valid) begin
            out_data_d = gnt_data;
            out_ch_d   = gnt_idx;
         end
      end
      if (gnt_valid && (mode_i == MODE_RR)) begin
         rr_ptr_d = (gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_data_o  = out_data_q;
   assign out_valid_o = out_valid_q;
   assign out_ch_o    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr (4 channels, 8 bits).
module tb_stream_mux_rr;
   import stream_pkg::*;

   localparam int NCH = 4;
   localparam int DW  = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          mode;
   logic [1:0]    sel;
   logic [31:0]   in_data;
   logic [3:0]    in_valid;
   logic [3:0]    in_ready;
   logic [7:0]    out_data;
   logic          out_valid;
   logic [1:0]    out_ch;
   logic          out_ready;

   int            n_chk = 0;
   int            n_err = 0;

   // Reference model state
   bit            m_ov;
   int            m_ptr;
   logic [9:0]    sb[$];
   logic [1:0]    ch_seq[5];

   always #5 clk = ~clk;

   stream_mux_rr #(
      .NUM_CH (NCH),
      .DATA_W (DW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mode_i      (mode),
      .sel_i       (sel),
      .in_data_i   (in_data),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .out_data_o  (out_data),
      .out_valid_o (out_valid),
      .out_ch_o    (out_ch),
      .out_ready_i (out_ready)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle (called at posedge+1), check mid-cycle, advance model at the edge
   task automatic step(input logic md, input logic [1:0] s, input logic [3:0] v,
                       input logic [31:0] d, input logic ordy);
      bit         load;
      bit         gv;
      int         g;
      int         idx;
      logic [3:0] exp_rdy;
      mode = md; sel = s; in_valid = v; in_data = d; out_ready = ordy;
      #3;
      load = !m_ov || ordy;
      gv = 1'b0;
      g = 0;
      if (md == MODE_FIXED) begin
         if (v[s]) begin
            gv = 1'b1;
            g = int'(s);
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            idx = (m_ptr + i) % NCH;
            if (!gv && v[idx]) begin
               gv = 1'b1;
               g = idx;
            end
         end
      end
      exp_rdy = (load && gv) ? 4'(1 << g) : 4'b0000;
      check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
      check_eq("out_valid", 32'(out_valid), 32'(m_ov));
      if (out_valid) begin
         if (sb.size() > 0) check_eq("out_word", 32'({out_ch, out_data}), 32'(sb[0]));
         else check_eq("out_valid_sb_empty", 32'(out_valid), 32'd0);
      end
      if (m_ov && ordy && sb.size() > 0) void'(sb.pop_front());
      if (load) m_ov = gv;
      if (load && gv) begin
         sb.push_back({2'(g), d[g*DW +: DW]});
         if (md == MODE_RR) m_ptr = (g == NCH - 1) ? 0 : g + 1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      m_ov = 1'b0;
      m_ptr = 0;
      rst_n = 1'b0;
      mode = MODE_FIXED;
      sel = 2'd0;
      in_data = 32'h0;
      in_valid = 4'b1111;
      out_ready = 1'b1;

      // Reset with all channels requesting
      #12;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_data", 32'(out_data), 32'd0);
      check_eq("rst_out_ch", 32'(out_ch), 32'd0);
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      in_valid = 4'b0000;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fixed mode, channel 2
      step(MODE_FIXED, 2'd2, 4'b0100, 32'h00A5_0000, 1'b1);
      check_eq("fix_data", 32'(out_data), 32'hA5);
      check_eq("fix_ch", 32'(out_ch), 32'd2);
      step(MODE_FIXED, 2'd2, 4'b0000, 32'h0, 1'b1);

      // Round-robin, all valid, no bubbles
      for (int i = 0; i < 5; i++) begin
         step(MODE_RR, 2'd0, 4'b1111, 32'h1312_1110, 1'b1);
         ch_seq[i] = out_ch;
         check_eq("rr_nobubble", 32'(out_valid), 32'd1);
      end
      check_eq("rr_seq0", 32'(ch_seq[0]), 32'd0);
      check_eq("rr_seq1", 32'(ch_seq[1]), 32'd1);
      check_eq("rr_seq2", 32'(ch_seq[2]), 32'd2);
      check_eq("rr_seq3", 32'(ch_seq[3]), 32'd3);
      check_eq("rr_seq4", 32'(ch_seq[4]), 32'd0);

      // Backpressure for three cycles, then release
      for (int i = 0; i < 3; i++) step(MODE_RR, 2'd0, 4'b1111, 32'h2322_2120, 1'b0);
      step(MODE_RR, 2'd0, 4'b1111, 32'h2322_2120, 1'b1);
      step(MODE_RR, 2'd0, 4'b0000, 32'h0, 1'b1);
      step(MODE_RR, 2'd0, 4'b0000, 32'h0, 1'b1);

      // Sparse round-robin wrap: land ptr on 3, then request 1, then 0 and 3
      step(MODE_RR, 2'd0, 4'b0100, 32'h0033_0000, 1'b1);
      step(MODE_RR, 2'd0, 4'b0010, 32'h0000_4400, 1'b1);
      check_eq("wrap_ch1", 32'(out_ch), 32'd1);
      step(MODE_RR, 2'd0, 4'b1001, 32'h5500_0066, 1'b1);
      check_eq("wrap_ch3", 32'(out_ch), 32'd3);
      step(MODE_RR, 2'd0, 4'b1001, 32'h5500_0066, 1'b1);
      check_eq("wrap_ch0", 32'(out_ch), 32'd0);

      // Fixed sel with invalid channel: pending word drains, then output idles
      step(MODE_FIXED, 2'd1, 4'b1101, 32'h7777_7777, 1'b0);
      step(MODE_FIXED, 2'd1, 4'b1101, 32'h7777_7777, 1'b0);
      step(MODE_FIXED, 2'd1, 4'b1101, 32'h7777_7777, 1'b1);
      step(MODE_FIXED, 2'd1, 4'b1101, 32'h7777_7777, 1'b1);
      check_eq("nogrant_idle", 32'(out_valid), 32'd0);

      // Reset asserted mid-cycle while a word is held
      step(MODE_RR, 2'd0, 4'b1111, 32'h8483_8281, 1'b0);
      step(MODE_RR, 2'd0, 4'b1111, 32'h8483_8281, 1'b0);
      rst_n = 1'b0;
      #1;
      check_eq("async_out_valid", 32'(out_valid), 32'd0);
      check_eq("async_out_data", 32'(out_data), 32'd0);
      check_eq("async_out_ch", 32'(out_ch), 32'd0);
      check_eq("async_in_ready", 32'(in_ready), 32'd0);
      sb.delete();
      m_ov = 1'b0;
      m_ptr = 0;
      in_valid = 4'b0000;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Random traffic with mode/sel switching and backpressure
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
              $urandom, ($urandom_range(0, 3) != 0));
      end
      // Drain
      for (int i = 0; i < 3; i++) step(MODE_RR, 2'd0, 4'b0000, 32'h0, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
